// File: rtl/dcache_pkg.sv
// Shared encodings and address helpers for the direct-mapped write-back data cache.
// Default geometry: 16 lines x 4 words, 32-bit byte addresses.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WBACK = 2'd1,
        ST_FILL  = 2'd2
    } dc_state_e;

    localparam int DC_LINES      = 16;
    localparam int DC_LINE_WORDS = 4;
    localparam int DC_ADDR_W     = 32;

    localparam int OFF_W  = $clog2(DC_LINE_WORDS);
    localparam int IDX_W  = $clog2(DC_LINES);
    localparam int TAG_W  = DC_ADDR_W - IDX_W - OFF_W - 2;
    localparam int LINE_W = 32 * DC_LINE_WORDS;

    // Extracts a w-bit field starting at bit lsb; callers narrow the result.
    function automatic logic [63:0] dc_field(input logic [63:0] a, input int lsb, input int w);
        return (a >> lsb) & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] dc_line_addr(input logic [63:0] tag, input logic [63:0] idx,
                                                 input int idx_w, input int off_w);
        return (tag << (idx_w + off_w + 2)) | (idx << (off_w + 2));
    endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Line storage for the data cache: async read of one line, single-word store
// port and full-line fill port (fill wins if both fire).
module dcache_data_array
    import dcache_pkg::*;
#(
    parameter int LINES = DC_LINES,
    parameter int IW    = IDX_W,
    parameter int OW    = OFF_W,
    parameter int LW    = LINE_W
) (
    input  logic          clk_i,
    input  logic [IW-1:0] idx_i,
    output logic [LW-1:0] rline_o,
    input  logic          word_we_i,
    input  logic [OW-1:0] word_off_i,
    input  logic [31:0]   word_i,
    input  logic          line_we_i,
    input  logic [LW-1:0] line_i
);

    logic [LW-1:0] line_q [LINES];

    assign rline_o = line_q[idx_i];

    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            line_q[idx_i] <= line_i;
        end else if (word_we_i) begin
            line_q[idx_i][{word_off_i, 5'b0} +: 32] <= word_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller (IDLE/WBACK/FILL).
// Optional DCACHE_PERF_CNT_EN adds saturating hit/miss counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES      = DC_LINES,
    parameter int LINE_WORDS = DC_LINE_WORDS,
    parameter int ADDR_W     = DC_ADDR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cpu_req_i,
    input  logic                     cpu_we_i,
    input  logic [ADDR_W-1:0]        cpu_addr_i,
    input  logic [31:0]              cpu_wdata_i,
    output logic [31:0]              cpu_rdata_o,
    output logic                     cpu_stall_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [32*LINE_WORDS-1:0] mem_wdata_o,
    input  logic [32*LINE_WORDS-1:0] mem_rdata_i,
    input  logic                     mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
   ,output logic [31:0]              hit_cnt_o,
    output logic [31:0]              miss_cnt_o
`endif
);

    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_W - IW - OW - 2;
    localparam int LW = 32 * LINE_WORDS;

    logic [OW-1:0] off;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;

    assign off = OW'(dc_field(64'(cpu_addr_i), 2, OW));
    assign idx = IW'(dc_field(64'(cpu_addr_i), OW + 2, IW));
    assign tag = TW'(dc_field(64'(cpu_addr_i), IW + OW + 2, TW));

    dc_state_e         state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;
    logic [TW-1:0]     tag_q [LINES];
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LW-1:0]     mem_wdata_q, mem_wdata_d;
    logic              post_fill_q, post_fill_d;

    logic          hit, miss, ack, word_we, line_we;
    logic [LW-1:0] rline;

    dcache_data_array #(
        .LINES (LINES),
        .IW    (IW),
        .OW    (OW),
        .LW    (LW)
    ) u_data (
        .clk_i      (clk_i),
        .idx_i      (idx),
        .rline_o    (rline),
        .word_we_i  (word_we),
        .word_off_i (off),
        .word_i     (cpu_wdata_i),
        .line_we_i  (line_we),
        .line_i     (mem_rdata_i)
    );

    always_comb begin
        hit  = !rst_i && cpu_req_i && (state_q == ST_IDLE) && valid_q[idx] && (tag_q[idx] == tag);
        miss = !rst_i && cpu_req_i && (state_q == ST_IDLE) && !hit;
        ack  = mem_req_q && mem_ack_i;

        cpu_stall_o = !rst_i && (miss || (state_q != ST_IDLE));
        cpu_rdata_o = (hit && !cpu_we_i) ? rline[{off, 5'b0} +: 32] : 32'd0;

        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        post_fill_d = post_fill_q;
        word_we     = 1'b0;
        line_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                post_fill_d = 1'b0;
                if (hit) begin
                    word_we = cpu_we_i;
                    if (cpu_we_i) dirty_d[idx] = 1'b1;
                end else if (miss) begin
                    mem_req_d = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d     = ST_WBACK;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ADDR_W'(dc_line_addr(64'(tag_q[idx]), 64'(idx), IW, OW));
                        mem_wdata_d = rline;
                    end else begin
                        state_d    = ST_FILL;
                        mem_we_d   = 1'b0;
                        mem_addr_d = ADDR_W'(dc_line_addr(64'(tag), 64'(idx), IW, OW));
                    end
                end
            end
            ST_WBACK: begin
                // Drop req for a cycle so the fill is a distinct request.
                if (ack) begin
                    state_d   = ST_FILL;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            ST_FILL: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = ADDR_W'(dc_line_addr(64'(tag), 64'(idx), IW, OW));
                end else if (ack) begin
                    line_we      = !rst_i;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = ST_IDLE;
                    mem_req_d    = 1'b0;
                    post_fill_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            post_fill_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            post_fill_q <= post_fill_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we) tag_q[idx] <= tag;
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // The hit that retires a filled miss belongs to that miss, not to the hit count.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit && !post_fill_q && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_d = hit_cnt_q + 32'd1;
        if (miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
